// File: rtl/accumulator_isoschedule_pkg.sv
// Shared definitions for the isoschedule accumulator: product width, run length
// limit, FSM state encodings and the run-length legality helper.
package accumulator_isoschedule_pkg;

  localparam int ACC_WIDTH   = 16;
  localparam int ACC_MAX_LEN = 64;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ACCUM = 2'd1;
  localparam logic [1:0] ST_HOLD  = 2'd2;

  function automatic logic len_is_legal(input int unsigned len, input int unsigned max_len);
    return (len != 32'd0) && (len <= max_len);
  endfunction

endpackage

// File: rtl/accumulator_isoschedule.sv
// Sums a run of len unsigned products from a valid/ready stream and holds the
// dot-product result on a valid/ready output until the next stage takes it.
module accumulator_isoschedule
  import accumulator_isoschedule_pkg::*;
#(
  parameter int ACC_W   = ACC_WIDTH,
  parameter int MAX_LEN = ACC_MAX_LEN,
  parameter int LEN_W   = $clog2(MAX_LEN + 1),
  parameter int OUT_W   = ACC_W + $clog2(MAX_LEN)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [LEN_W-1:0] len,
  input  logic             prod_valid,
  input  logic [ACC_W-1:0] prod,
  output logic             prod_ready,
  output logic             sum_valid,
  output logic [OUT_W-1:0] sum,
  input  logic             sum_ready,
  output logic             busy,
  output logic             len_err
);

  logic [1:0]       state_q, state_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [LEN_W-1:0] cnt_q, cnt_d;
  logic [OUT_W-1:0] acc_q, acc_d;
  logic [OUT_W-1:0] sum_q, sum_d;
  logic             sum_valid_q, sum_valid_d;
  logic             len_err_q, len_err_d;

  logic             beat_s;
  logic [OUT_W-1:0] acc_next_s;
  logic             last_beat_s;

  // prod_ready comes from state alone so prod_valid never reaches an output combinationally
  assign prod_ready  = (state_q == ST_ACCUM);
  assign busy        = (state_q != ST_IDLE);
  assign sum_valid   = sum_valid_q;
  assign sum         = sum_q;
  assign len_err     = len_err_q;

  assign beat_s      = prod_valid & prod_ready;
  assign acc_next_s  = acc_q + OUT_W'(prod);
  assign last_beat_s = (cnt_q == (len_q - LEN_W'(1)));

  always_comb begin
    state_d     = state_q;
    len_d       = len_q;
    cnt_d       = cnt_q;
    acc_d       = acc_q;
    sum_d       = sum_q;
    sum_valid_d = sum_valid_q;
    len_err_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (len_is_legal(32'(len), MAX_LEN)) begin
            len_d   = len;
            cnt_d   = '0;
            acc_d   = '0;
            state_d = ST_ACCUM;
          end else begin
            len_err_d = 1'b1;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ACCUM: begin
        if (beat_s) begin
          acc_d = acc_next_s;
          cnt_d = cnt_q + LEN_W'(1);
          if (last_beat_s) begin
            sum_d       = acc_next_s;
            sum_valid_d = 1'b1;
            state_d     = ST_HOLD;
          end else begin
            state_d = ST_ACCUM;
          end
        end else begin
          state_d = ST_ACCUM;
        end
      end
      ST_HOLD: begin
        if (sum_valid_q && sum_ready) begin
          sum_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end else begin
          state_d = ST_HOLD;
        end
      end
      default: begin
        state_d     = ST_IDLE;
        sum_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      len_q       <= '0;
      cnt_q       <= '0;
      acc_q       <= '0;
      sum_q       <= '0;
      sum_valid_q <= 1'b0;
      len_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      cnt_q       <= cnt_d;
      acc_q       <= acc_d;
      sum_q       <= sum_d;
      sum_valid_q <= sum_valid_d;
      len_err_q   <= len_err_d;
    end
  end

endmodule
